// File: rtl/sc_level_down_timer_if.sv
// Level/time bus between the up-level counter, the level timer and the game FSM.
// The master side drives level and controls; the slave side is the timer.
interface sc_level_down_timer_if #(
    parameter int LEVEL_DATAWIDTH = 8,
    parameter int TIME_DATAWIDTH  = 8
);
    logic [LEVEL_DATAWIDTH-1:0] level_InBUS;
    logic                       start_InLow;
    logic                       pause_InLow;
    logic [TIME_DATAWIDTH-1:0]  time_OutBUS;
    logic                       expired_OutPulse;
    logic                       running_OutHigh;
    logic                       warn_OutHigh;

    modport master (
        output level_InBUS, start_InLow, pause_InLow,
        input  time_OutBUS, expired_OutPulse, running_OutHigh, warn_OutHigh
    );

    modport slave (
        input  level_InBUS, start_InLow, pause_InLow,
        output time_OutBUS, expired_OutPulse, running_OutHigh, warn_OutHigh
    );
endinterface

// File: rtl/sc_level_down_timer.sv
// Per-level Frogger countdown: higher level loads less time, one decrement per tick.
// Optional blinking low-time warning is built when LEVELTIMER_WARN_EN is defined.
module sc_level_down_timer #(
    parameter int LEVEL_DATAWIDTH = 8,
    parameter int TIME_DATAWIDTH  = 8,
    parameter int PRESCALER_MAX   = 50000000,
    parameter int PRESCALER_WIDTH = 26,
    parameter int BASE_TIME       = 60,
    parameter int STEP_TIME       = 4,
    parameter int MIN_TIME        = 10,
    parameter int WARN_TIME       = 5
) (
    input logic SC_upLEVELCOUNTER_CLOCK_50,
    input logic SC_upLEVELCOUNTER_RESET_InHigh,
    sc_level_down_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    localparam int PW = LEVEL_DATAWIDTH + TIME_DATAWIDTH;
    localparam logic [PW-1:0] SPAN = PW'(BASE_TIME - MIN_TIME);
    localparam logic [PRESCALER_WIDTH-1:0] PRE_LAST =
        PRESCALER_WIDTH'(PRESCALER_MAX - 1);

    state_t                      state;
    state_t                      state_n;
    logic [TIME_DATAWIDTH-1:0]   count;
    logic [TIME_DATAWIDTH-1:0]   count_n;
    logic [PRESCALER_WIDTH-1:0]  pre;
    logic [PRESCALER_WIDTH-1:0]  pre_n;
    logic                        expired;
    logic                        expired_n;
    logic [PW-1:0]               prod;
    logic [TIME_DATAWIDTH-1:0]   load;

    // prod < SPAN < 2^TIME_DATAWIDTH on the subtract path, so truncation is safe
    assign prod = PW'(bus.level_InBUS) * PW'(STEP_TIME);
    assign load = (prod >= SPAN) ? TIME_DATAWIDTH'(MIN_TIME)
                                 : TIME_DATAWIDTH'(BASE_TIME) - prod[TIME_DATAWIDTH-1:0];

    always_comb begin
        state_n   = state;
        count_n   = count;
        pre_n     = pre;
        expired_n = 1'b0;
        if (!bus.start_InLow) begin
            state_n = RUN;
            count_n = load;
            pre_n   = '0;
        end else begin
            unique case (state)
                IDLE: count_n = '0;
                RUN: begin
                    if (!bus.pause_InLow) begin
                        state_n = PAUSE;
                    end else if (pre == PRE_LAST) begin
                        pre_n = '0;
                        if (count != '0) count_n = count - 1'b1;
                        if (count == TIME_DATAWIDTH'(1)) begin
                            state_n   = EXPIRED;
                            expired_n = 1'b1;
                        end
                    end else begin
                        pre_n = pre + 1'b1;
                    end
                end
                PAUSE: if (bus.pause_InLow) state_n = RUN;
                EXPIRED: count_n = '0;
            endcase
        end
    end

    always_ff @(posedge SC_upLEVELCOUNTER_CLOCK_50 or posedge SC_upLEVELCOUNTER_RESET_InHigh) begin
        if (SC_upLEVELCOUNTER_RESET_InHigh) begin
            state   <= IDLE;
            count   <= '0;
            pre     <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            pre     <= pre_n;
            expired <= expired_n;
        end
    end

    assign bus.time_OutBUS      = count;
    assign bus.expired_OutPulse = expired;
    assign bus.running_OutHigh  = (state == RUN);

`ifdef LEVELTIMER_WARN_EN
    localparam logic [PRESCALER_WIDTH-1:0] HALF =
        PRESCALER_WIDTH'(PRESCALER_MAX / 2);

    logic warn;
    logic warn_n;
    logic in_band;

    // Blinks on the prescaler half-period while running, steady while paused
    always_comb begin
        in_band = (count_n != '0) && (count_n <= TIME_DATAWIDTH'(WARN_TIME));
        warn_n  = 1'b0;
        if (in_band) begin
            if (state_n == PAUSE) warn_n = 1'b1;
            else if (state_n == RUN) warn_n = (pre_n < HALF);
        end
    end

    always_ff @(posedge SC_upLEVELCOUNTER_CLOCK_50 or posedge SC_upLEVELCOUNTER_RESET_InHigh) begin
        if (SC_upLEVELCOUNTER_RESET_InHigh) warn <= 1'b0;
        else warn <= warn_n;
    end

    assign bus.warn_OutHigh = warn;
`else
    assign bus.warn_OutHigh = 1'b0;
`endif
endmodule

// File: tb/tb_sc_level_down_timer.sv
// Scoreboard bench for sc_level_down_timer with a 4-cycle prescaler.
// Stimulus queues expected bus values per cycle; a negedge monitor checks them.
module tb_sc_level_down_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        int    cyc;
        int    t;
        bit    run;
        bit    ex;
        string nm;
    } exp_t;

    exp_t q[$];
    exp_t e;

    sc_level_down_timer_if #(.LEVEL_DATAWIDTH(8), .TIME_DATAWIDTH(8)) bus ();

    sc_level_down_timer #(
        .PRESCALER_MAX(4),
        .PRESCALER_WIDTH(3)
    ) u_dut (
        .SC_upLEVELCOUNTER_CLOCK_50(clk),
        .SC_upLEVELCOUNTER_RESET_InHigh(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    task automatic push_exp(input int offs, input int t, input bit run,
                            input bit ex, input string nm);
        exp_t x;
        x.cyc = cyc + offs;
        x.t   = t;
        x.run = run;
        x.ex  = ex;
        x.nm  = nm;
        q.push_back(x);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk({e.nm, "_cyc"}, cyc, e.cyc);
            chk({e.nm, "_time"}, int'(bus.time_OutBUS), e.t);
            chk({e.nm, "_run"}, int'(bus.running_OutHigh), int'(e.run));
            chk({e.nm, "_exp"}, int'(bus.expired_OutPulse), int'(e.ex));
`ifndef LEVELTIMER_WARN_EN
            chk({e.nm, "_warn"}, int'(bus.warn_OutHigh), 0);
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    int lv[6] = '{12, 20, 255, 2, 13, 0};
    int ld[6] = '{12, 10, 10, 52, 10, 60};

    initial begin
        bus.level_InBUS = 8'd0;
        bus.start_InLow = 1'b1;
        bus.pause_InLow = 1'b1;

        // reset and idle hold
        tick(3);
        rst = 1'b0;
        push_exp(0, 0, 0, 0, "rst");
        push_exp(50, 0, 0, 0, "idle50");
        push_exp(100, 0, 0, 0, "idle100");
        tick(100);

        // level 0 load and first two decrements
        bus.start_InLow = 1'b0;
        push_exp(1, 60, 1, 0, "load60");
        tick(1);
        bus.start_InLow = 1'b1;
        push_exp(3, 60, 1, 0, "pre_tick");
        push_exp(4, 59, 1, 0, "dec59");
        push_exp(8, 58, 1, 0, "dec58");
        tick(8);

        // load table, level sampled only on start
        for (int i = 0; i < 6; i++) begin
            bus.level_InBUS = 8'(lv[i]);
            bus.start_InLow = 1'b0;
            push_exp(1, ld[i], 1, 0, $sformatf("load_lv%0d", lv[i]));
            tick(1);
            bus.start_InLow = 1'b1;
            bus.level_InBUS = 8'd100;
            push_exp(2, ld[i], 1, 0, $sformatf("hold_lv%0d", lv[i]));
            tick(2);
        end

        // expiry at level 12: 48 cycles
        bus.level_InBUS = 8'd12;
        bus.start_InLow = 1'b0;
        tick(1);
        bus.start_InLow = 1'b1;
        push_exp(44, 1, 1, 0, "last1");
        push_exp(47, 1, 1, 0, "pre_exp");
        push_exp(48, 0, 0, 1, "expire");
        push_exp(49, 0, 0, 0, "exp_once");
        push_exp(60, 0, 0, 0, "exp_hold");
        push_exp(69, 0, 0, 0, "exp_hold2");
        tick(70);

        // pause freezes time and prescaler
        bus.level_InBUS = 8'd0;
        bus.start_InLow = 1'b0;
        tick(1);
        bus.start_InLow = 1'b1;
        push_exp(12, 57, 1, 0, "at57");
        push_exp(13, 57, 1, 0, "at57b");
        tick(13);
        bus.pause_InLow = 1'b0;
        push_exp(1, 57, 0, 0, "paused");
        push_exp(10, 57, 0, 0, "paused10");
        tick(10);
        bus.pause_InLow = 1'b1;
        push_exp(1, 57, 1, 0, "resume");
        push_exp(3, 57, 1, 0, "resume_pre");
        push_exp(4, 56, 1, 0, "resume_dec");
        tick(4);
        bus.pause_InLow = 1'b0;
        tick(2);
        bus.start_InLow = 1'b0;
        push_exp(1, 60, 1, 0, "start_in_pause");
        tick(1);
        bus.start_InLow = 1'b1;
        bus.pause_InLow = 1'b1;
        push_exp(1, 60, 1, 0, "run_after_pause");
        tick(5);

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_time", int'(bus.time_OutBUS), 0);
        chk("async_rst_run", int'(bus.running_OutHigh), 0);
        tick(2);
        rst = 1'b0;
        push_exp(0, 0, 0, 0, "post_rst");
        push_exp(5, 0, 0, 0, "post_rst5");
        tick(7);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sc_level_down_timer.md
Name:
sc_level_down_timer

Overview:
- Per-level countdown timer for the Frogger game; the consuming end of the up-level counter's data bus.
- Samples the current level on start and loads a level-dependent time budget: higher level gives less time.
- Decrements once per prescaled tick and pulses expired at zero.
- Sits between the level counter and the game-control FSM and score/lives logic; drives the on-screen time bar.

Parameters:
- LEVEL_DATAWIDTH, 8, width of level input bus.
- TIME_DATAWIDTH, 8, width of time count output.
- PRESCALER_MAX, 50000000, clock cycles per time unit (1 s at 50 MHz); must be >= 2.
- PRESCALER_WIDTH, 26, prescaler register width; must satisfy 2^PRESCALER_WIDTH >= PRESCALER_MAX.
- BASE_TIME, 60, time loaded at level 0.
- STEP_TIME, 4, time removed per level.
- MIN_TIME, 10, floor of loaded time; must satisfy 1 <= MIN_TIME <= BASE_TIME < 2^TIME_DATAWIDTH.
- WARN_TIME, 5, warning threshold; used only with LEVELTIMER_WARN_EN.

Ports:
- SC_upLEVELCOUNTER_CLOCK_50  in  1  system clock, 50 MHz.
- SC_upLEVELCOUNTER_RESET_InHigh  in  1  asynchronous, active-high reset.
- level_InBUS  in  LEVEL_DATAWIDTH  current level from level counter.
- start_InLow  in  1  level-sensitive start/reload, active low.
- pause_InLow  in  1  freeze countdown while low.
- time_OutBUS  out  TIME_DATAWIDTH  remaining time.
- expired_OutPulse  out  1  one-cycle pulse on reaching zero.
- running_OutHigh  out  1  high in RUN state.
- warn_OutHigh  out  1  low-time warning (see Optional Feature).

Behaviour:
- Clock: SC_upLEVELCOUNTER_CLOCK_50. Reset: SC_upLEVELCOUNTER_RESET_InHigh, asynchronous, active-high.
- Reset values: state IDLE, time 0, prescaler 0, expired_OutPulse 0, running_OutHigh 0, warn_OutHigh 0.
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Load value:
  - prod = level * STEP_TIME, computed at LEVEL_DATAWIDTH+TIME_DATAWIDTH bits (no overflow).
  - If prod >= BASE_TIME-MIN_TIME, load = MIN_TIME; otherwise load = BASE_TIME-prod.
- FSM states: IDLE, RUN, PAUSE, EXPIRED.
- start_InLow low at a clock edge, in any state:
  - time <= load, prescaler <= 0, next state RUN.
  - start has priority over pause and over the tick.
  - Holding start low keeps reloading, so no countdown occurs while it is held.
- IDLE: hold; time stays 0.
- RUN:
  - prescaler increments each cycle.
  - When prescaler == PRESCALER_MAX-1: prescaler <= 0 and time <= time-1. The first decrement therefore lands exactly PRESCALER_MAX cycles after the load edge.
  - If that decrement takes time from 1 to 0: next state EXPIRED and expired_OutPulse = 1 for exactly that one following cycle.
- RUN with pause_InLow low (and start high): next state PAUSE; no tick that cycle; prescaler and time frozen.
- PAUSE:
  - Frozen while pause_InLow is low.
  - Returns to RUN when pause_InLow goes high; prescaler resumes from its frozen value, so no tick is lost or duplicated.
- EXPIRED: time held at 0; no further pulses; leaves only via start or reset.
- running_OutHigh = (state == RUN).
- level_InBUS is sampled only on the start edge; later level changes do not affect a countdown in progress.
- time never wraps below 0. Loaded value never exceeds BASE_TIME and is always >= MIN_TIME >= 1.
- Reset mid-countdown: all registers cleared immediately, independent of the clock.

Optional Feature:
- Macro: LEVELTIMER_WARN_EN.
- Defined:
  - warn_OutHigh = 1 when state is RUN or PAUSE and 0 < time <= WARN_TIME; registered.
  - Toggles at a 50 % duty cycle, half-period = PRESCALER_MAX/2 cycles, using the prescaler MSB comparison, while in RUN.
  - Steady high in PAUSE.
- Undefined: warn_OutHigh tied to 0; no warning logic synthesized.

Test Plan:
1. Assert reset with clock running, then release -> time_OutBUS=0, running 0, expired 0, state IDLE; no change with start and pause held high for 100 cycles.
2. PRESCALER_MAX=4, level=0, start low for 1 cycle -> next edge time=60, running=1; time=59 four cycles later; time=58 after four more.
3. Load math: level=12 -> load 12; level=20 -> load 10 (floor); level=255 -> load 10; level=2 -> load 52.
4. PRESCALER_MAX=4, level=12, start -> time reaches 0 at 48 cycles after load; expired_OutPulse high for exactly 1 cycle; state EXPIRED; time stays 0 for 20 more cycles with no further pulse.
5. Level=0, run to time=57, pause low 10 cycles -> time and prescaler frozen, running=0; release -> next decrement occurs after the remaining prescaler count. Start low while paused -> time=60, RUN.
6. Mid-countdown, assert reset between clock edges -> time=0 and state IDLE immediately. With LEVELTIMER_WARN_EN, WARN_TIME=5: warn rises when time=5 and stays 0 at time=6.
